// File: rtl/tmr_regfile.sv
// tmr_regfile: register file with per-bit triple redundancy, majority-voted
// reads, a background scrubber that rewrites entries with their voted value,
// a saturating corrected-mismatch counter and a copy-level fault-injection port.
module tmr_regfile #(
  parameter int             W            = 12,
  parameter int             DEPTH        = 8,
  parameter int             AW           = 3,
  parameter logic [W-1:0]   TRIPLICATE   = {W{1'b1}},
  parameter logic [W-1:0]   RESET_VAL    = {W{1'b0}},
  parameter int             SCRUB_PERIOD = 64,
  parameter int             CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_data,
  output logic             rd_err,
  input  logic             scrub_en,
  output logic [AW-1:0]    scrub_ptr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             inj_en,
  input  logic [AW-1:0]    inj_addr,
  input  logic [1:0]       inj_copy,
  input  logic [W-1:0]     inj_mask
);

  localparam int TW = $clog2(SCRUB_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_PERIOD - 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);

  // Majority per triplicated bit; single-copy bits pass c0 straight through.
  function automatic logic [W-1:0] vote_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    return (TRIPLICATE & ((a & b) | (b & c) | (a & c))) | (~TRIPLICATE & a);
  endfunction

  // Any disagreement among the copies of a triplicated bit.
  function automatic logic mismatch_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c);
    return |(TRIPLICATE & ((a ^ b) | (b ^ c)));
  endfunction

  logic [W-1:0]     c0_r [DEPTH];
  logic [W-1:0]     c1_r [DEPTH];
  logic [W-1:0]     c2_r [DEPTH];
  logic [W-1:0]     c0_nxt_s [DEPTH];
  logic [W-1:0]     c1_nxt_s [DEPTH];
  logic [W-1:0]     c2_nxt_s [DEPTH];
  logic [W-1:0]     voted_s [DEPTH];
  logic             mism_s [DEPTH];

  logic [TW-1:0]    timer_r;
  logic             pending_r;
  logic [AW-1:0]    ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     rd_data_r;
  logic             rd_err_r;

  logic             terminal_s;
  logic             scrub_step_s;
  logic             inj_hit_s;
  logic [1:0]       inc_s;
  logic [CNT_W:0]   sum_s;

  // Voted value and mismatch flag of every entry.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      voted_s[e] = vote_f(c0_r[e], c1_r[e], c2_r[e]);
      mism_s[e]  = mismatch_f(c0_r[e], c1_r[e], c2_r[e]);
    end
  end

  // Scrub scheduling, injection qualification and error-event sum.
  always_comb begin
    terminal_s   = scrub_en && (timer_r == TIMER_LAST);
    scrub_step_s = pending_r && !wr_en;
    inj_hit_s    = inj_en && !(wr_en && (wr_addr == inj_addr));
    inc_s        = {1'b0, mism_s[rd_addr]} + {1'b0, scrub_step_s & mism_s[ptr_r]};
    sum_s        = {1'b0, cnt_r} + {{(CNT_W-1){1'b0}}, inc_s};
  end

  // Next copy contents: write beats scrub; injection XORs on top unless
  // a write targets the same entry this cycle.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en && (wr_addr == AW'(e))) begin
        c0_nxt_s[e] = wr_data;
        c1_nxt_s[e] = wr_data;
        c2_nxt_s[e] = wr_data;
      end else if (scrub_step_s && (ptr_r == AW'(e))) begin
        c0_nxt_s[e] = voted_s[e];
        c1_nxt_s[e] = voted_s[e];
        c2_nxt_s[e] = voted_s[e];
      end else begin
        c0_nxt_s[e] = c0_r[e];
        c1_nxt_s[e] = c1_r[e];
        c2_nxt_s[e] = c2_r[e];
      end
      if (inj_hit_s && (inj_addr == AW'(e))) begin
        case (inj_copy)
          2'd0:    c0_nxt_s[e] = c0_nxt_s[e] ^ inj_mask;
          2'd1:    c1_nxt_s[e] = c1_nxt_s[e] ^ (inj_mask & TRIPLICATE);
          2'd2:    c2_nxt_s[e] = c2_nxt_s[e] ^ (inj_mask & TRIPLICATE);
          default: c0_nxt_s[e] = c0_nxt_s[e];
        endcase
      end else begin
        c0_nxt_s[e] = c0_nxt_s[e];
      end
      // Single-copy positions have no c1/c2 storage: tie them off.
      c1_nxt_s[e] = (c1_nxt_s[e] & TRIPLICATE) | (RESET_VAL & ~TRIPLICATE);
      c2_nxt_s[e] = (c2_nxt_s[e] & TRIPLICATE) | (RESET_VAL & ~TRIPLICATE);
    end
  end

  // Copy storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < DEPTH; e++) begin
        c0_r[e] <= RESET_VAL;
        c1_r[e] <= RESET_VAL;
        c2_r[e] <= RESET_VAL;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        c0_r[e] <= c0_nxt_s[e];
        c1_r[e] <= c1_nxt_s[e];
        c2_r[e] <= c2_nxt_s[e];
      end
    end
  end

  // Scrub timer, pending flag and pointer; a terminal count with a step
  // already pending is absorbed rather than queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_r   <= {TW{1'b0}};
      pending_r <= 1'b0;
      ptr_r     <= {AW{1'b0}};
    end else begin
      if (scrub_en) begin
        timer_r <= terminal_s ? {TW{1'b0}} : timer_r + {{(TW-1){1'b0}}, 1'b1};
      end
      if (scrub_step_s) begin
        pending_r <= 1'b0;
        ptr_r     <= (ptr_r == PTR_LAST) ? {AW{1'b0}} : ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        pending_r <= pending_r | terminal_s;
      end
    end
  end

  // Registered read port (sees storage before this edge's updates).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_r <= RESET_VAL;
      rd_err_r  <= 1'b0;
    end else begin
      rd_data_r <= voted_s[rd_addr];
      rd_err_r  <= mism_s[rd_addr];
    end
  end

  // Saturating error counter; clear has priority over increments.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (sum_s[CNT_W]) begin
      cnt_r <= {CNT_W{1'b1}};
    end else begin
      cnt_r <= sum_s[CNT_W-1:0];
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_err    = rd_err_r;
  assign scrub_ptr = ptr_r;
  assign err_cnt   = cnt_r;

endmodule

// File: tb/tb_tmr_regfile.sv
// Randomised self-checking bench for tmr_regfile with an array-based model.
module tb_tmr_regfile;
  localparam int          W     = 12;
  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam logic [11:0] TRIP  = 12'h0FF;
  localparam int          PER   = 16;
  localparam int          CMAX  = 255;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_err;
  logic          scrub_en = 1'b0;
  logic [AW-1:0] scrub_ptr;
  logic          err_clr = 1'b0;
  logic [7:0]    err_cnt;
  logic          inj_en = 1'b0;
  logic [AW-1:0] inj_addr = '0;
  logic [1:0]    inj_copy = '0;
  logic [W-1:0]  inj_mask = '0;

  tmr_regfile #(.W(W), .DEPTH(DEPTH), .AW(AW), .TRIPLICATE(TRIP), .RESET_VAL(12'h000),
                .SCRUB_PERIOD(PER), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err), .scrub_en(scrub_en),
    .scrub_ptr(scrub_ptr), .err_clr(err_clr), .err_cnt(err_cnt), .inj_en(inj_en),
    .inj_addr(inj_addr), .inj_copy(inj_copy), .inj_mask(inj_mask));

  always #5 clk = ~clk;

  // Model state: three full-width copies per entry; only the masked bits matter.
  logic [W-1:0] m0 [DEPTH];
  logic [W-1:0] m1 [DEPTH];
  logic [W-1:0] m2 [DEPTH];
  int m_timer, m_ptr, m_cnt;
  bit m_pend;
  logic [W-1:0] m_rd;
  bit m_err;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] mvote(int e);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      if (TRIP[b]) r[b] = ((int'(m0[e][b]) + int'(m1[e][b]) + int'(m2[e][b])) >= 2);
      else         r[b] = m0[e][b];
    end
    return r;
  endfunction

  function automatic bit mmism(int e);
    bit r = 0;
    for (int b = 0; b < W; b++)
      if (TRIP[b] && !(m0[e][b] == m1[e][b] && m1[e][b] == m2[e][b])) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) begin
      m0[e] = '0; m1[e] = '0; m2[e] = '0;
    end
    m_timer = 0; m_ptr = 0; m_cnt = 0; m_pend = 0; m_rd = '0; m_err = 0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model from the inputs now applied, then compare.
  task automatic cycle();
    int  inc;
    bit  step, term;
    logic [W-1:0] v;
    if (!rstn) begin
      model_reset();
    end else begin
      step = m_pend && !wr_en;
      term = scrub_en && (m_timer == PER - 1);
      m_rd  = mvote(rd_addr);
      m_err = mmism(rd_addr);
      inc = m_err ? 1 : 0;
      if (step && mmism(m_ptr)) inc++;
      if (err_clr) m_cnt = 0;
      else m_cnt = (m_cnt + inc > CMAX) ? CMAX : m_cnt + inc;
      if (step) begin
        v = mvote(m_ptr);
        m0[m_ptr] = v; m1[m_ptr] = v; m2[m_ptr] = v;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (wr_en) begin
        m0[wr_addr] = wr_data; m1[wr_addr] = wr_data; m2[wr_addr] = wr_data;
      end
      if (inj_en && !(wr_en && wr_addr == inj_addr)) begin
        if (inj_copy == 2'd0) m0[inj_addr] = m0[inj_addr] ^ inj_mask;
        if (inj_copy == 2'd1) m1[inj_addr] = m1[inj_addr] ^ inj_mask;
        if (inj_copy == 2'd2) m2[inj_addr] = m2[inj_addr] ^ inj_mask;
      end
      m_pend = step ? 0 : (m_pend | term);
      if (scrub_en) m_timer = term ? 0 : m_timer + 1;
    end
    @(posedge clk);
    #1;
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("rd_err", 32'(rd_err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("scrub_ptr", 32'(scrub_ptr), 32'(m_ptr));
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; inj_en = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    int guard;
    int p0;
    model_reset();
    #3;
    chk("reset rd_data", 32'(rd_data), 32'h0);
    chk("reset err_cnt", 32'(err_cnt), 32'h0);
    chk("reset scrub_ptr", 32'(scrub_ptr), 32'h0);
    cycle();
    cycle();
    rstn = 1'b1;

    // Read every entry after reset.
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      cycle();
      chk("init rd_data", 32'(rd_data), 32'h000);
      chk("init rd_err", 32'(rd_err), 32'h0);
      chk("init err_cnt", 32'(err_cnt), 32'h0);
    end
    rd_addr = 3'd0;

    // Single-copy corruption on a triplicated nibble is voted out.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 12'hABC;
    cycle();
    wr_en = 1'b0;
    inj_en = 1'b1; inj_addr = 3'd3; inj_copy = 2'd1; inj_mask = 12'h00F;
    cycle();
    inj_en = 1'b0;
    rd_addr = 3'd3;
    cycle();
    chk("tmr rd_data", 32'(rd_data), 32'hABC);
    chk("tmr rd_err", 32'(rd_err), 32'h1);
    chk("tmr err_cnt", 32'(err_cnt), 32'd1);
    cycle();
    chk("reread err_cnt", 32'(err_cnt), 32'd2);
    rd_addr = 3'd0;
    cycle();

    // Scrub repairs entry 3 and counts exactly one event.
    scrub_en = 1'b1;
    guard = 0;
    while (m_ptr != 4 && guard < 10 * PER) begin
      cycle();
      guard++;
    end
    if (guard >= 10 * PER) begin
      miscompares++;
      $display("FAIL scrub_wait: scrub pointer never reached 4");
    end
    scrub_en = 1'b0;
    chk("scrub err_cnt", 32'(err_cnt), 32'd3);
    rd_addr = 3'd3;
    cycle();
    chk("scrubbed rd_data", 32'(rd_data), 32'hABC);
    chk("scrubbed rd_err", 32'(rd_err), 32'h0);
    rd_addr = 3'd0;

    // Single-copy bit: upset is uncorrectable and copy 1 does not exist there.
    inj_en = 1'b1; inj_addr = 3'd2; inj_copy = 2'd0; inj_mask = 12'h100;
    cycle();
    inj_copy = 2'd1;
    rd_addr = 3'd2;
    cycle();
    inj_en = 1'b0;
    chk("single rd_data", 32'(rd_data), 32'h100);
    chk("single rd_err", 32'(rd_err), 32'h0);
    cycle();
    chk("copy1 noeffect rd_data", 32'(rd_data), 32'h100);
    chk("copy1 noeffect rd_err", 32'(rd_err), 32'h0);
    rd_addr = 3'd0;

    // Writes stall a pending scrub step.
    p0 = m_ptr;
    scrub_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 12'h5A5;
    for (int i = 0; i < PER + 4; i++) cycle();
    chk("stall scrub_ptr", 32'(scrub_ptr), 32'(p0));
    wr_en = 1'b0; scrub_en = 1'b0;
    cycle();
    chk("release scrub_ptr", 32'(scrub_ptr), 32'((p0 + 1) % DEPTH));
    cycle();
    chk("once scrub_ptr", 32'(scrub_ptr), 32'((p0 + 1) % DEPTH));

    // Counter saturation and clear priority.
    inj_en = 1'b1; inj_addr = 3'd5; inj_copy = 2'd2; inj_mask = 12'h001;
    cycle();
    inj_en = 1'b0;
    rd_addr = 3'd5;
    for (int i = 0; i < 260; i++) cycle();
    chk("sat err_cnt", 32'(err_cnt), 32'd255);
    cycle();
    chk("sat hold err_cnt", 32'(err_cnt), 32'd255);
    err_clr = 1'b1;
    cycle();
    chk("clr err_cnt", 32'(err_cnt), 32'd0);
    err_clr = 1'b0;
    rd_addr = 3'd0;
    cycle();

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rstn = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        rstn = 1'b1;
      end
      wr_en    = ($urandom_range(0, 99) < 25);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = W'($urandom);
      rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      scrub_en = ($urandom_range(0, 99) < 85);
      err_clr  = ($urandom_range(0, 99) < 2);
      inj_en   = ($urandom_range(0, 99) < 20);
      inj_addr = AW'($urandom_range(0, DEPTH - 1));
      inj_copy = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) inj_mask = W'($urandom);
      else inj_mask = W'(12'h001 << $urandom_range(0, W - 1));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
